// File: rtl/lcd_display_pkg.sv
// ---------------------------------------------------------------------------
// lcd_display_pkg
// Shared definitions for the HD44780 character-LCD sequencer:
//   - bit positions of the fields inside an 11-bit command ROM word
//   - the sequencer state enum
//   - lcd_cyc(): converts a wait time in microseconds into clock cycles
//   - the ASCII space used for out-of-range live-data selections
// No ports; imported by lcd_display and lcd_delay_timer.
// ---------------------------------------------------------------------------
package lcd_display_pkg;

  // Command word layout: [10]=RS, [9]=RW, [8]=SEL, [7:0]=BYTE
  localparam int CMD_WIDTH    = 11;
  localparam int CMD_RS_BIT   = 10;
  localparam int CMD_RW_BIT   = 9;
  localparam int CMD_SEL_BIT  = 8;
  localparam int CMD_BYTE_MSB = 7;

  // Instruction bytes that need the long execution wait (clear / return home)
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Shown when a live-data word selects a byte that does not exist
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SETUP,
    PULSE,
    HOLD,
    NEXT
  } lcd_state_e;

  // Cycles needed to cover tUs microseconds at clockHz, rounded up and never
  // below one. 64-bit arithmetic keeps fast clocks with long waits exact.
  function automatic int lcd_cyc(input int tUs, input int clockHz);
    longint prod;
    longint cycles;
    prod   = longint'(tUs) * longint'(clockHz);
    cycles = (prod + 64'sd999999) / 64'sd1000000;
    if (cycles < 64'sd1) begin
      cycles = 64'sd1;
    end
    return int'(cycles);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// ---------------------------------------------------------------------------
// lcd_delay_timer
// Loadable down-counter that times the E-strobe and execution waits.
// Loading value N-1 makes o_done rise N cycles later (o_done is high in the
// last cycle of the wait), so the caller leaves its state after exactly N.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  synchronous active-low reset, clears the count
//   i_load   load i_value this cycle (takes priority over counting)
//   i_value  count to load
//   o_done   count has reached zero
// ---------------------------------------------------------------------------
module lcd_delay_timer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_done
);

  logic [WIDTH-1:0] count_q;

  // Count down to zero and park there until the next load; a load always
  // wins so the sequencer can chain the strobe wait straight into the
  // execution wait without a dead cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else if (i_load) begin
      count_q <= i_value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign o_done = (count_q == '0);

endmodule

// File: rtl/lcd_display.sv
// ---------------------------------------------------------------------------
// lcd_display
// Sequencer for an HD44780-style LCD on an 8-bit bus. Walks the window
// [i_addr_begin..i_addr_end] of an external command ROM forever, putting
// each word on the LCD pins with an E strobe and the execution wait the
// controller needs, so the screen keeps refreshing from live data.
// Ports:
//   i_clk, i_rst_n  clock and synchronous active-low reset
//   i_command       ROM word at o_addr, valid one cycle after o_addr changes
//   i_data          SIZE-1 live bytes, byte k = i_data[8k+7:8k]
//   i_addr_begin    first ROM address of the window
//   i_addr_end      last ROM address of the window (inclusive)
//   o_addr          ROM read address
//   o_data          LCD DB7..DB0
//   o_E, o_RS, o_RW LCD enable strobe, register select, read/write
// ---------------------------------------------------------------------------
module lcd_display
  import lcd_display_pkg::*;
#(
  parameter int SIZE          = 4,
  parameter int WIDTH_MEM_MAX = 4,
  parameter int CLOCK         = 25000
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [CMD_WIDTH-1:0]       i_command,
  input  logic [(SIZE-1)*8-1:0]      i_data,
  input  logic [WIDTH_MEM_MAX-1:0]   i_addr_begin,
  input  logic [WIDTH_MEM_MAX-1:0]   i_addr_end,
  output logic [WIDTH_MEM_MAX-1:0]   o_addr,
  output logic [7:0]                 o_data,
  output logic                       o_E,
  output logic                       o_RS,
  output logic                       o_RW
);

  localparam int E_CYC    = lcd_cyc(1, CLOCK);
  localparam int EXEC_CYC = lcd_cyc(50, CLOCK);
  localparam int CLR_CYC  = lcd_cyc(2000, CLOCK);
  localparam int TIMER_W  = $clog2(CLR_CYC) + 1;

  lcd_state_e                 state_q;
  logic                       timerLoad;
  logic [TIMER_W-1:0]         timerValue;
  logic                       timerDone;
  logic [7:0]                 cmdByte;
  logic [7:0]                 selByte;
  logic [7:0]                 cmdData;
  logic                       isClear;
  logic [WIDTH_MEM_MAX-1:0]   addr_d;

  assign cmdByte = i_command[CMD_BYTE_MSB:0];

  // Live-data selection: BYTE indexes i_data, and any index past the last
  // byte shows a blank so a bad ROM word cannot print garbage.
  always_comb begin
    selByte = SPACE;
    for (int k = 0; k < SIZE - 1; k++) begin
      if (cmdByte == 8'(k)) begin
        selByte = i_data[8*k +: 8];
      end
    end
  end

  assign cmdData = i_command[CMD_SEL_BIT] ? selByte : cmdByte;

  // Clear display and return home run for milliseconds; decided from the
  // already-latched bus so it reflects the word currently being strobed.
  assign isClear = !o_RS && ((o_data == CMD_CLEAR) || (o_data == CMD_HOME));

  // Advance through the window; begin>end wraps naturally through the top
  // of the address space because the add is W bits wide.
  assign addr_d = (o_addr == i_addr_end) ? i_addr_begin : o_addr + 1'b1;

  // Timer loads: the strobe wait starts as SETUP hands over to PULSE, and the
  // execution wait is chained in on the cycle the strobe ends. Values are
  // N-1 because the timer reports done in its final cycle.
  always_comb begin
    timerLoad  = 1'b0;
    timerValue = '0;
    if (state_q == SETUP) begin
      timerLoad  = 1'b1;
      timerValue = TIMER_W'(E_CYC - 1);
    end else if ((state_q == PULSE) && timerDone) begin
      timerLoad  = 1'b1;
      timerValue = isClear ? TIMER_W'(CLR_CYC - 1) : TIMER_W'(EXEC_CYC - 1);
    end
  end

  lcd_delay_timer #(
    .WIDTH   (TIMER_W)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (timerLoad),
    .i_value (timerValue),
    .o_done  (timerDone)
  );

  // Main sequencer. All LCD pins are registered here. RS/RW/DB are taken
  // from the ROM word only when leaving SETUP, which is also the only place
  // i_data is sampled, so the bus is frozen for the whole strobe and the
  // execution wait. E rises on that same edge; the controller captures on
  // E falling, a full strobe width later.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      o_addr  <= '0;
      o_data  <= '0;
      o_E     <= 1'b0;
      o_RS    <= 1'b0;
      o_RW    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          o_addr  <= i_addr_begin;
          state_q <= FETCH;
        end
        FETCH: begin
          state_q <= SETUP;
        end
        SETUP: begin
          o_RS    <= i_command[CMD_RS_BIT];
          o_RW    <= i_command[CMD_RW_BIT];
          o_data  <= cmdData;
          o_E     <= 1'b1;
          state_q <= PULSE;
        end
        PULSE: begin
          if (timerDone) begin
            o_E     <= 1'b0;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (timerDone) begin
            state_q <= NEXT;
          end
        end
        NEXT: begin
          o_addr  <= addr_d;
          state_q <= FETCH;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_display.sv
// ---------------------------------------------------------------------------
// tb_lcd_display
// Directed bench for lcd_display at 25 kHz (40 us period) with a small
// registered ROM model. Each E pulse is checked for address, RS, RW and bus
// value, its width, the length of the following low phase (execution wait
// plus NEXT, FETCH and SETUP = wait + 3) and bus stability while E is low.
// ---------------------------------------------------------------------------
`timescale 1us/1ns
module tb_lcd_display;

  localparam int SIZE  = 4;
  localparam int W     = 4;
  localparam int CLOCK = 25000;

  // Execution wait 2 cycles, clear wait 50 cycles, plus 3 sequencing cycles
  localparam int LOW_EXEC = 5;
  localparam int LOW_CLR  = 53;

  logic                  clock = 1'b0;
  logic                  rstN;
  logic [10:0]           romData;
  logic [(SIZE-1)*8-1:0] liveData;
  logic [W-1:0]          addrBegin;
  logic [W-1:0]          addrEnd;
  logic [W-1:0]          oAddr;
  logic [7:0]            oData;
  logic                  oE;
  logic                  oRs;
  logic                  oRw;

  logic [10:0]           rom [16];

  int checks = 0;
  int errors = 0;

  lcd_display #(
    .SIZE          (SIZE),
    .WIDTH_MEM_MAX (W),
    .CLOCK         (CLOCK)
  ) dut (
    .i_clk        (clock),
    .i_rst_n      (rstN),
    .i_command    (romData),
    .i_data       (liveData),
    .i_addr_begin (addrBegin),
    .i_addr_end   (addrEnd),
    .o_addr       (oAddr),
    .o_data       (oData),
    .o_E          (oE),
    .o_RS         (oRs),
    .o_RW         (oRw)
  );

  // 40 us clock period
  always #20 clock = ~clock;

  // Command ROM with a one-cycle registered read
  always @(posedge clock) begin
    romData <= rom[oAddr];
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive the window and live data inputs
  task automatic applyStimulus(input logic [W-1:0] b, input logic [W-1:0] e,
                               input logic [(SIZE-1)*8-1:0] d);
    addrBegin = b;
    addrEnd   = e;
    liveData  = d;
  endtask

  // Called at a negedge; waits for the next E pulse, checks it, and returns
  // at the negedge where the following pulse is already high.
  task automatic checkPulse(input string tag, input logic [W-1:0] expAddr,
                            input logic expRs, input logic expRw,
                            input logic [7:0] expData, input int expLow);
    int         waitN;
    int         highN;
    int         lowN;
    logic [7:0] capData;
    logic       capRs;
    logic       capRw;
    logic       moved;
    waitN = 0;
    while (oE !== 1'b1 && waitN < 400) begin
      @(negedge clock);
      waitN++;
    end
    checkOutput({tag, "_rise"}, 32'(oE), 32'd1);
    capData = oData;
    capRs   = oRs;
    capRw   = oRw;
    checkOutput({tag, "_addr"}, 32'(oAddr), 32'(expAddr));
    checkOutput({tag, "_rs"},   32'(oRs),   32'(expRs));
    checkOutput({tag, "_rw"},   32'(oRw),   32'(expRw));
    checkOutput({tag, "_data"}, 32'(oData), 32'(expData));
    highN = 0;
    while (oE === 1'b1 && highN < 400) begin
      highN++;
      @(negedge clock);
    end
    moved = 1'b0;
    lowN  = 0;
    while (oE === 1'b0 && lowN < 400) begin
      if (oData !== capData || oRs !== capRs || oRw !== capRw) begin
        moved = 1'b1;
      end
      lowN++;
      @(negedge clock);
    end
    checkOutput({tag, "_high"},   32'(highN), 32'd1);
    checkOutput({tag, "_low"},    32'(lowN),  32'(expLow));
    checkOutput({tag, "_stable"}, 32'(moved), 32'd0);
  endtask

  // Directed sequence: reset, two refresh passes of window 6..9 with a live
  // data change, reset during HOLD into a single-word window holding a
  // clear command, then a wrapping window 14..1 reached via live updates.
  initial begin
    for (int i = 0; i < 16; i++) begin
      rom[i] = 11'h020;
    end
    rom[5]  = 11'h001;
    rom[6]  = 11'h038;
    rom[7]  = 11'h500;
    rom[8]  = 11'h501;
    rom[9]  = 11'h503;
    rom[14] = 11'h44E;
    rom[15] = 11'h44F;
    rom[0]  = 11'h630;
    rom[1]  = 11'h431;

    rstN = 1'b0;
    applyStimulus(4'd6, 4'd9, 24'h000FFF);
    @(negedge clock);
    $display("[TB] reset applied");
    checkOutput("rst_e",    32'(oE),    32'd0);
    checkOutput("rst_rs",   32'(oRs),   32'd0);
    checkOutput("rst_rw",   32'(oRw),   32'd0);
    checkOutput("rst_data", 32'(oData), 32'd0);
    checkOutput("rst_addr", 32'(oAddr), 32'd0);

    rstN = 1'b1;
    @(negedge clock);
    checkOutput("idle_addr", 32'(oAddr), 32'd6);
    checkOutput("idle_e",    32'(oE),    32'd0);

    checkPulse("w6a",  4'd6, 1'b0, 1'b0, 8'h38, LOW_EXEC);
    checkPulse("w7a",  4'd7, 1'b1, 1'b0, 8'hFF, LOW_EXEC);
    checkPulse("w8a",  4'd8, 1'b1, 1'b0, 8'h0F, LOW_EXEC);
    checkPulse("w9a",  4'd9, 1'b1, 1'b0, 8'h20, LOW_EXEC);

    applyStimulus(4'd6, 4'd9, 24'h00F000);
    checkPulse("w6b",  4'd6, 1'b0, 1'b0, 8'h38, LOW_EXEC);
    checkPulse("w7b",  4'd7, 1'b1, 1'b0, 8'h00, LOW_EXEC);
    checkPulse("w8b",  4'd8, 1'b1, 1'b0, 8'hF0, LOW_EXEC);
    checkPulse("w9b",  4'd9, 1'b1, 1'b0, 8'h20, LOW_EXEC);

    // Pulse for address 6 is high now; the next edge enters HOLD
    applyStimulus(4'd5, 4'd5, 24'h00F000);
    @(negedge clock);
    checkOutput("hold_e", 32'(oE), 32'd0);
    rstN = 1'b0;
    @(negedge clock);
    checkOutput("hrst_e",    32'(oE),    32'd0);
    checkOutput("hrst_rs",   32'(oRs),   32'd0);
    checkOutput("hrst_data", 32'(oData), 32'd0);
    checkOutput("hrst_addr", 32'(oAddr), 32'd0);
    rstN = 1'b1;

    checkPulse("w5a",  4'd5, 1'b0, 1'b0, 8'h01, LOW_CLR);
    checkPulse("w5b",  4'd5, 1'b0, 1'b0, 8'h01, LOW_CLR);
    applyStimulus(4'd14, 4'd5, 24'h00F000);
    checkPulse("w5c",  4'd5, 1'b0, 1'b0, 8'h01, LOW_CLR);
    checkPulse("w14a", 4'd14, 1'b1, 1'b0, 8'h4E, LOW_EXEC);
    applyStimulus(4'd14, 4'd1, 24'h00F000);
    checkPulse("w15",  4'd15, 1'b1, 1'b0, 8'h4F, LOW_EXEC);
    checkPulse("w0",   4'd0, 1'b1, 1'b1, 8'h30, LOW_EXEC);
    checkPulse("w1",   4'd1, 1'b1, 1'b0, 8'h31, LOW_EXEC);
    checkPulse("w14b", 4'd14, 1'b1, 1'b0, 8'h4E, LOW_EXEC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
